iob_dma_mc_sched: RTL and testbench

Multi-channel command scheduler for the DMA engine. It holds N_CH independent memory-to-memory transfer descriptors. Each transfer is split into chunks of at most 2**CHUNK_W words. Chunks are issued one at a time, in round-robin order across channels, to a single downstream AXI manager engine (read path plus write path). It sits between the register file and the AXI manager core. It adds channel count, chunk-level fairness, per-channel fixed/incrementing address modes and abort, which the single-channel DMA lacks.

---
 rtl/iob_dma_mc_sched.sv | 210 +++++++++++++++++++++
 tb/tb_iob_dma_mc_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/iob_dma_mc_sched.sv
// Multi-channel DMA command scheduler: splits per-channel transfers into chunks and issues
// them round-robin to a single AXI manager engine, one chunk in flight at a time.
module iob_dma_mc_sched #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned LENGTH_W = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CHUNK_W  = 8,
  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cke_i,
  input  logic [N_CH*ADDR_W-1:0]   ch_src_addr_i,
  input  logic [N_CH*ADDR_W-1:0]   ch_dst_addr_i,
  input  logic [N_CH*LENGTH_W-1:0] ch_length_i,
  input  logic [N_CH-1:0]          ch_src_fixed_i,
  input  logic [N_CH-1:0]          ch_dst_fixed_i,
  input  logic [N_CH-1:0]          ch_start_i,
  input  logic [N_CH-1:0]          ch_abort_i,
  output logic [N_CH-1:0]          ch_busy_o,
  output logic [N_CH-1:0]          ch_done_o,
  output logic [N_CH-1:0]          ch_aborted_o,
  output logic [N_CH-1:0]          ch_err_o,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [CH_W-1:0]          cmd_ch_o,
  output logic [ADDR_W-1:0]        cmd_src_addr_o,
  output logic [ADDR_W-1:0]        cmd_dst_addr_o,
  output logic [CHUNK_W:0]         cmd_length_o,
  output logic                     cmd_src_fixed_o,
  output logic                     cmd_dst_fixed_o,
  input  logic                     eng_done_i
);

  localparam int unsigned MaxChunk = 1 << CHUNK_W;

  typedef enum logic [1:0] {StIdle, StArb, StIssue, StWait} state_e;

  state_e state_q, state_d;
  logic [CH_W-1:0] rr_q, rr_d;

  logic [ADDR_W-1:0]   src_q [N_CH];
  logic [ADDR_W-1:0]   dst_q [N_CH];
  logic [LENGTH_W-1:0] rem_q [N_CH];
  logic [N_CH-1:0]     sfix_q, dfix_q, busy_q, abort_pend_q, done_q, aborted_q, err_q;

  logic [CH_W-1:0]   cmd_ch_q;
  logic [ADDR_W-1:0] cmd_src_q, cmd_dst_q;
  logic [CHUNK_W:0]  cmd_len_q;
  logic              cmd_sfix_q, cmd_dfix_q;

  logic              any_pend;
  logic [CH_W-1:0]   pick;
  logic [CHUNK_W:0]  pick_len;
  logic              flight_vld;
  logic [CH_W-1:0]   flight_ch;
  logic              wait_done;
  logic [LENGTH_W-1:0] new_rem;
  logic              retire;
  logic [ADDR_W-1:0] step;
  logic [N_CH-1:0]   cur_oh;

  // Nothing is in flight in IDLE/ARB, so busy equals pending there.
  always_comb begin
    any_pend = 1'b0;
    pick     = rr_q;
    for (int i = 1; i <= int'(N_CH); i++) begin
      logic [CH_W-1:0] cand;
      cand = CH_W'((32'(rr_q) + 32'(i)) % N_CH);
      if (!any_pend && busy_q[cand]) begin
        any_pend = 1'b1;
        pick     = cand;
      end
    end
  end

  always_comb begin
    pick_len   = (32'(rem_q[pick]) > MaxChunk) ? (CHUNK_W+1)'(MaxChunk)
                                               : (CHUNK_W+1)'(rem_q[pick]);
    flight_vld = (state_q == StArb && any_pend) || state_q == StIssue || state_q == StWait;
    flight_ch  = (state_q == StArb) ? pick : cmd_ch_q;
    wait_done  = (state_q == StWait) && eng_done_i;
    new_rem    = rem_q[cmd_ch_q] - LENGTH_W'(cmd_len_q);
    retire     = abort_pend_q[cmd_ch_q] || ch_abort_i[cmd_ch_q] || (new_rem == '0);
    step       = ADDR_W'(32'(cmd_len_q) * (DATA_W / 8));
    cur_oh     = N_CH'(1) << cmd_ch_q;
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    unique case (state_q)
      StIdle:  if (|busy_q) state_d = StArb;
      StArb: begin
        if (any_pend) begin
          state_d = StIssue;
          rr_d    = pick;
        end else begin
          state_d = StIdle;
        end
      end
      StIssue: if (cmd_ready_i) state_d = StWait;
      StWait: begin
        if (eng_done_i) begin
          state_d = ((|(busy_q & ~cur_oh)) || !retire) ? StArb : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      rr_q       <= CH_W'(N_CH - 1);
      cmd_ch_q   <= '0;
      cmd_src_q  <= '0;
      cmd_dst_q  <= '0;
      cmd_len_q  <= '0;
      cmd_sfix_q <= 1'b0;
      cmd_dfix_q <= 1'b0;
    end else if (cke_i) begin
      state_q <= state_d;
      rr_q    <= rr_d;
      if (state_q == StArb && any_pend) begin
        cmd_ch_q   <= pick;
        cmd_src_q  <= src_q[pick];
        cmd_dst_q  <= dst_q[pick];
        cmd_len_q  <= pick_len;
        cmd_sfix_q <= sfix_q[pick];
        cmd_dfix_q <= dfix_q[pick];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < int'(N_CH); k++) begin
        src_q[k] <= '0;
        dst_q[k] <= '0;
        rem_q[k] <= '0;
      end
      sfix_q       <= '0;
      dfix_q       <= '0;
      busy_q       <= '0;
      abort_pend_q <= '0;
      done_q       <= '0;
      aborted_q    <= '0;
      err_q        <= '0;
    end else if (cke_i) begin
      done_q <= '0;
      err_q  <= '0;
      for (int k = 0; k < int'(N_CH); k++) begin
        if (ch_start_i[k] && !busy_q[k]) begin
          aborted_q[k]    <= 1'b0;
          abort_pend_q[k] <= 1'b0;
          if (ch_length_i[k*LENGTH_W +: LENGTH_W] == '0) begin
            done_q[k] <= 1'b1;
          end else begin
            busy_q[k] <= 1'b1;
            src_q[k]  <= ch_src_addr_i[k*ADDR_W +: ADDR_W];
            dst_q[k]  <= ch_dst_addr_i[k*ADDR_W +: ADDR_W];
            rem_q[k]  <= ch_length_i[k*LENGTH_W +: LENGTH_W];
            sfix_q[k] <= ch_src_fixed_i[k];
            dfix_q[k] <= ch_dst_fixed_i[k];
          end
        end else begin
          if (ch_start_i[k]) err_q[k] <= 1'b1;
          if (busy_q[k]) begin
            if (wait_done && cmd_ch_q == CH_W'(k)) begin
              rem_q[k] <= new_rem;
              if (!cmd_sfix_q) src_q[k] <= src_q[k] + step;
              if (!cmd_dfix_q) dst_q[k] <= dst_q[k] + step;
              if (retire) begin
                busy_q[k]       <= 1'b0;
                done_q[k]       <= 1'b1;
                aborted_q[k]    <= abort_pend_q[k] || ch_abort_i[k];
                abort_pend_q[k] <= 1'b0;
              end
            end else if (ch_abort_i[k]) begin
              // An in-flight chunk must finish; retirement waits for its eng_done_i.
              if (flight_vld && flight_ch == CH_W'(k)) begin
                abort_pend_q[k] <= 1'b1;
              end else begin
                busy_q[k]    <= 1'b0;
                rem_q[k]     <= '0;
                done_q[k]    <= 1'b1;
                aborted_q[k] <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

  assign ch_busy_o       = busy_q;
  assign ch_done_o       = done_q;
  assign ch_aborted_o    = aborted_q;
  assign ch_err_o        = err_q;
  assign cmd_valid_o     = (state_q == StIssue);
  assign cmd_ch_o        = cmd_ch_q;
  assign cmd_src_addr_o  = cmd_src_q;
  assign cmd_dst_addr_o  = cmd_dst_q;
  assign cmd_length_o    = cmd_len_q;
  assign cmd_src_fixed_o = cmd_sfix_q;
  assign cmd_dst_fixed_o = cmd_dfix_q;

endmodule

// File: tb/tb_iob_dma_mc_sched.sv
// Directed bench for iob_dma_mc_sched: the engine side is driven by hand, one chunk at a time.
module tb_iob_dma_mc_sched;

  localparam int N_CH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cke = 1'b1;
  logic [127:0] ch_src_addr = '0;
  logic [127:0] ch_dst_addr = '0;
  logic [63:0]  ch_length = '0;
  logic [3:0]  ch_src_fixed = '0;
  logic [3:0]  ch_dst_fixed = '0;
  logic [3:0]  ch_start = '0;
  logic [3:0]  ch_abort = '0;
  logic [3:0]  ch_busy, ch_done, ch_aborted, ch_err;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [1:0]  cmd_ch;
  logic [31:0] cmd_src_addr, cmd_dst_addr;
  logic [8:0]  cmd_length;
  logic        cmd_src_fixed, cmd_dst_fixed;
  logic        eng_done = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  iob_dma_mc_sched #(
    .N_CH(4), .ADDR_W(32), .LENGTH_W(16), .DATA_W(32), .CHUNK_W(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cke_i(cke),
    .ch_src_addr_i(ch_src_addr), .ch_dst_addr_i(ch_dst_addr), .ch_length_i(ch_length),
    .ch_src_fixed_i(ch_src_fixed), .ch_dst_fixed_i(ch_dst_fixed),
    .ch_start_i(ch_start), .ch_abort_i(ch_abort),
    .ch_busy_o(ch_busy), .ch_done_o(ch_done), .ch_aborted_o(ch_aborted), .ch_err_o(ch_err),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_ch_o(cmd_ch),
    .cmd_src_addr_o(cmd_src_addr), .cmd_dst_addr_o(cmd_dst_addr), .cmd_length_o(cmd_length),
    .cmd_src_fixed_o(cmd_src_fixed), .cmd_dst_fixed_o(cmd_dst_fixed),
    .eng_done_i(eng_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int k, input logic [31:0] s, input logic [31:0] d,
                      input logic [15:0] l, input logic sf, input logic df);
    ch_src_addr[k*32 +: 32] = s;
    ch_dst_addr[k*32 +: 32] = d;
    ch_length[k*16 +: 16]   = l;
    ch_src_fixed[k]         = sf;
    ch_dst_fixed[k]         = df;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
  endtask

  // Expect one chunk command, accept it after one stall cycle, then report completion.
  task automatic issue(input string tag, input int ch, input logic [31:0] s,
                       input logic [31:0] d, input int len, input logic df);
    wait_valid();
    chk({tag, ".valid"}, cmd_valid, 1);
    chk({tag, ".ch"}, cmd_ch, ch);
    chk({tag, ".src"}, cmd_src_addr, s);
    chk({tag, ".dst"}, cmd_dst_addr, d);
    chk({tag, ".len"}, cmd_length, len);
    chk({tag, ".dfix"}, cmd_dst_fixed, df);
    step();
    chk({tag, ".hold"}, cmd_valid, 1);
    chk({tag, ".hold_src"}, cmd_src_addr, s);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    chk({tag, ".wait"}, cmd_valid, 0);
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    chk("rst.valid", cmd_valid, 0);
    chk("rst.busy", ch_busy, 0);
    chk("rst.done", ch_done, 0);
    chk("rst.aborted", ch_aborted, 0);
    chk("rst.err", ch_err, 0);
    chk("rst.cmd_len", cmd_length, 0);

    // Three chunks of one transfer on channel 0.
    load(0, 32'h1000, 32'h8000, 16'd600, 1'b0, 1'b0);
    ch_start = 4'b0001;
    step();
    ch_start = 4'b0000;
    chk("t1.busy", ch_busy, 4'b0001);
    issue("t1.c0", 0, 32'h1000, 32'h8000, 256, 1'b0);
    chk("t1.nodone0", ch_done, 0);
    issue("t1.c1", 0, 32'h1400, 32'h8400, 256, 1'b0);
    chk("t1.nodone1", ch_done, 0);
    issue("t1.c2", 0, 32'h1800, 32'h8800, 88, 1'b0);
    chk("t1.done", ch_done, 4'b0001);
    chk("t1.busy_fall", ch_busy, 0);
    step();
    chk("t1.done_pulse", ch_done, 0);

    // Round robin after reset: pointer starts at the last channel.
    rst = 1'b1;
    step();
    rst = 1'b0;
    load(0, 32'h0000, 32'h0100, 16'd512, 1'b0, 1'b0);
    load(2, 32'h0200, 32'h0300, 16'd256, 1'b0, 1'b0);
    ch_start = 4'b0101;
    step();
    ch_start = 4'b0000;
    chk("t2.busy", ch_busy, 4'b0101);
    issue("t2.a", 0, 32'h0000, 32'h0100, 256, 1'b0);
    issue("t2.b", 2, 32'h0200, 32'h0300, 256, 1'b0);
    chk("t2.done2", ch_done, 4'b0100);
    issue("t2.c", 0, 32'h0400, 32'h0500, 256, 1'b0);
    chk("t2.done0", ch_done, 4'b0001);

    // Fixed destination.
    load(1, 32'h3000, 32'h0040, 16'd300, 1'b0, 1'b1);
    ch_start = 4'b0010;
    step();
    ch_start = 4'b0000;
    issue("t3.a", 1, 32'h3000, 32'h0040, 256, 1'b1);
    issue("t3.b", 1, 32'h3400, 32'h0040, 44, 1'b1);
    chk("t3.done", ch_done, 4'b0010);

    // Abort while the first of four chunks is in flight.
    load(3, 32'h0, 32'h0, 16'd1024, 1'b0, 1'b0);
    ch_start = 4'b1000;
    step();
    ch_start = 4'b0000;
    wait_valid();
    chk("t4.ch", cmd_ch, 3);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    ch_abort = 4'b1000;
    step();
    ch_abort = 4'b0000;
    chk("t4.pend_done", ch_done, 0);
    chk("t4.pend_busy", ch_busy, 4'b1000);
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("t4.done", ch_done, 4'b1000);
    chk("t4.aborted", ch_aborted, 4'b1000);
    chk("t4.busy", ch_busy, 0);
    step(5);
    chk("t4.no_cmd", cmd_valid, 0);
    chk("t4.sticky", ch_aborted, 4'b1000);

    // Start on a busy channel leaves the descriptor alone.
    load(0, 32'h5000, 32'h6000, 16'd300, 1'b0, 1'b0);
    ch_start = 4'b0001;
    step();
    load(0, 32'h9999, 32'h9999, 16'd5, 1'b0, 1'b0);
    step();
    ch_start = 4'b0000;
    chk("t5.err", ch_err, 4'b0001);
    step();
    chk("t5.err_pulse", ch_err, 0);
    issue("t5.a", 0, 32'h5000, 32'h6000, 256, 1'b0);
    issue("t5.b", 0, 32'h5400, 32'h6400, 44, 1'b0);
    chk("t5.done", ch_done, 4'b0001);

    // A new start clears the sticky abort flag.
    load(3, 32'h0010, 32'h0020, 16'd1, 1'b0, 1'b0);
    ch_start = 4'b1000;
    step();
    ch_start = 4'b0000;
    chk("t5.aborted_clr", ch_aborted, 0);
    issue("t5.one", 3, 32'h0010, 32'h0020, 1, 1'b0);
    chk("t5.one_done", ch_done, 4'b1000);

    // Zero length, plus pulse hold under clock enable low.
    load(2, 32'h0, 32'h0, 16'd0, 1'b0, 1'b0);
    ch_start = 4'b0100;
    step();
    ch_start = 4'b0000;
    chk("t5.len0_done", ch_done, 4'b0100);
    chk("t5.len0_busy", ch_busy, 0);
    cke = 1'b0;
    step();
    chk("t5.cke_hold", ch_done, 4'b0100);
    cke = 1'b1;
    step();
    chk("t5.cke_rel", ch_done, 0);
    step(3);
    chk("t5.len0_nocmd", cmd_valid, 0);

    // Reset during a stalled command.
    load(1, 32'h0700, 32'h0800, 16'd10, 1'b0, 1'b0);
    ch_start = 4'b0010;
    step();
    ch_start = 4'b0000;
    wait_valid();
    chk("t6.valid", cmd_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6.valid_drop", cmd_valid, 0);
    chk("t6.busy", ch_busy, 0);
    chk("t6.done", ch_done, 0);
    step(3);
    chk("t6.quiet", cmd_valid, 0);
    chk("t6.nodone", ch_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
